// File: rtl/int_ctrl_if.sv
// Signal bundle between int_ctrl and its control unit / CPU side.
// The master modport drives request lines and strobes; the slave modport is the controller.
interface int_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = 2
);
    logic [NUM_SRC-1:0] irq_in;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               int_ack;
    logic               int_ret;
    logic               int_sig;
    logic [IDW-1:0]     int_id;
    logic [7:0]         int_vec;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               in_service;

    modport master (
        output irq_in, mask_we, mask_wdata, int_ack, int_ret,
        input  int_sig, int_id, int_vec, pending, mask, in_service
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, int_ack, int_ret,
        output int_sig, int_id, int_vec, pending, mask, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// Edge-latching, fixed-priority interrupt controller with IDLE/REQ/ACTIVE handshake.
// Optional INTC_SYNC_EN inserts a two-flop synchroniser ahead of edge detection.
module int_ctrl #(
    parameter int                 NUM_SRC  = 4,
    parameter int                 IDW      = 2,
    parameter logic [7:0]         VEC_BASE = 8'h01,
    parameter logic [NUM_SRC-1:0] MASK_RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    int_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_q_reg;
    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] mask_reg;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] cand;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     int_id_reg, int_id_next;
    logic [7:0]         int_vec_reg;
    logic               int_sig_reg;
    logic               in_service_reg;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync_a_reg, sync_b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_reg <= '0;
            sync_b_reg <= '0;
        end else begin
            sync_a_reg <= bus.irq_in;
            sync_b_reg <= sync_a_reg;
        end
    end

    assign irq_s = sync_b_reg;
`else
    assign irq_s = bus.irq_in;
`endif

    // History tracks the line level during reset so a line already high at release is not an edge.
    always_ff @(posedge clk) begin
        irq_q_reg <= irq_s;
    end

    assign irq_edge = irq_s & ~irq_q_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign ack_clr[gi] = (state_reg == S_REQ) && bus.int_ack && (int_id_reg == IDW'(gi));

            // A coincident new edge beats the acknowledge clear.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pending_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= irq_edge[gi] | (pending_reg[gi] & ~ack_clr[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= MASK_RST;
        end else if (bus.mask_we) begin
            mask_reg <= bus.mask_wdata;
        end
    end

    assign cand = pending_reg & ~mask_reg;

    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        int_id_next = int_id_reg;
        case (state_reg)
            S_IDLE: begin
                if (|cand) begin
                    state_next  = S_REQ;
                    int_id_next = win_id;
                end
            end
            S_REQ: begin
                if (bus.int_ack) begin
                    state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (bus.int_ret) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            int_id_reg     <= '0;
            int_vec_reg    <= VEC_BASE;
            int_sig_reg    <= 1'b0;
            in_service_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            int_id_reg     <= int_id_next;
            int_vec_reg    <= VEC_BASE + 8'(int_id_next);
            int_sig_reg    <= (state_next == S_REQ);
            in_service_reg <= (state_next == S_ACTIVE);
        end
    end

    assign bus.int_sig    = int_sig_reg;
    assign bus.int_id     = int_id_reg;
    assign bus.int_vec    = int_vec_reg;
    assign bus.pending    = pending_reg;
    assign bus.mask       = mask_reg;
    assign bus.in_service = in_service_reg;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; latency offsets follow INTC_SYNC_EN.
module tb_int_ctrl;
    localparam int NUM_SRC = 4;
    localparam int IDW     = 2;
`ifdef INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    int_ctrl_if #(.NUM_SRC(NUM_SRC), .IDW(IDW)) bus ();

    int_ctrl #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW),
        .VEC_BASE(8'h01),
        .MASK_RST(4'b0000)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [NUM_SRC-1:0] lines);
        bus.irq_in = lines;
        tick();
        bus.irq_in = '0;
        repeat (LAT) tick();
    endtask

    task automatic do_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic do_ret();
        bus.int_ret = 1'b1;
        tick();
        bus.int_ret = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, " pending"},    32'(bus.pending),    32'h0);
        chk({pfx, " mask"},       32'(bus.mask),       32'h0);
        chk({pfx, " int_sig"},    32'(bus.int_sig),    32'h0);
        chk({pfx, " int_id"},     32'(bus.int_id),     32'h0);
        chk({pfx, " int_vec"},    32'(bus.int_vec),    32'h01);
        chk({pfx, " in_service"}, 32'(bus.in_service), 32'h0);
    endtask

    initial begin
        bus.irq_in     = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.int_ack    = 1'b0;
        bus.int_ret    = 1'b0;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst");

        // Single source 2: latency, id, vector, ack and return.
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = '0;
        for (int i = 0; i < LAT; i++) begin
            chk("t1 int_sig early", 32'(bus.int_sig), 32'h0);
            tick();
        end
        chk("t1 pending", 32'(bus.pending), 32'h4);
        chk("t1 int_sig k", 32'(bus.int_sig), 32'h0);
        tick();
        chk("t1 int_sig k+1", 32'(bus.int_sig), 32'h1);
        chk("t1 int_id", 32'(bus.int_id), 32'h2);
        chk("t1 int_vec", 32'(bus.int_vec), 32'h03);
        do_ack();
        chk("t1 ack pending", 32'(bus.pending), 32'h0);
        chk("t1 ack in_service", 32'(bus.in_service), 32'h1);
        chk("t1 ack int_sig", 32'(bus.int_sig), 32'h0);
        do_ret();
        chk("t1 ret in_service", 32'(bus.in_service), 32'h0);
        chk("t1 ret int_sig", 32'(bus.int_sig), 32'h0);

        // Simultaneous sources 3 and 1: lowest index first.
        pulse_irq(4'b1010);
        chk("t2 pending", 32'(bus.pending), 32'hA);
        tick();
        chk("t2 first id", 32'(bus.int_id), 32'h1);
        chk("t2 first vec", 32'(bus.int_vec), 32'h02);
        do_ack();
        do_ret();
        tick();
        chk("t2 second sig", 32'(bus.int_sig), 32'h1);
        chk("t2 second id", 32'(bus.int_id), 32'h3);
        chk("t2 second vec", 32'(bus.int_vec), 32'h04);
        do_ack();
        do_ret();
        tick();
        chk("t2 idle sig", 32'(bus.int_sig), 32'h0);
        chk("t2 idle pending", 32'(bus.pending), 32'h0);

        // Masked source latches but is not requested until unmasked.
        bus.mask_we = 1'b1;
        bus.mask_wdata = 4'b0010;
        tick();
        bus.mask_we = 1'b0;
        chk("t3 mask", 32'(bus.mask), 32'h2);
        pulse_irq(4'b0010);
        chk("t3 pending", 32'(bus.pending), 32'h2);
        tick();
        chk("t3 masked sig", 32'(bus.int_sig), 32'h0);
        bus.mask_we = 1'b1;
        bus.mask_wdata = 4'b0000;
        tick();
        bus.mask_we = 1'b0;
        chk("t3 write cycle sig", 32'(bus.int_sig), 32'h0);
        tick();
        chk("t3 unmasked sig", 32'(bus.int_sig), 32'h1);
        chk("t3 unmasked id", 32'(bus.int_id), 32'h1);
        do_ack();
        do_ret();

        // New edge coincident with ack on the same bit: set wins.
        pulse_irq(4'b0001);
        tick();
        chk("t4 req id", 32'(bus.int_id), 32'h0);
        chk("t4 req sig", 32'(bus.int_sig), 32'h1);
        bus.irq_in = 4'b0001;
        bus.int_ack = 1'b1;
        tick();
        bus.irq_in = '0;
        bus.int_ack = 1'b0;
        repeat (LAT) tick();
        chk("t4 set wins pending", 32'(bus.pending), 32'h1);
        chk("t4 in_service", 32'(bus.in_service), 32'h1);
        do_ack();
        chk("t4 ack in ACTIVE ignored svc", 32'(bus.in_service), 32'h1);
        chk("t4 ack in ACTIVE ignored pnd", 32'(bus.pending), 32'h1);
        do_ret();
        chk("t4 ret sig", 32'(bus.int_sig), 32'h0);
        tick();
        chk("t4 reassert sig", 32'(bus.int_sig), 32'h1);
        chk("t4 reassert id", 32'(bus.int_id), 32'h0);
        bus.int_ack = 1'b1;
        bus.int_ret = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.int_ret = 1'b0;
        chk("t4 ack+ret in REQ svc", 32'(bus.in_service), 32'h1);
        do_ret();
        do_ret();
        chk("t4 ret in IDLE svc", 32'(bus.in_service), 32'h0);
        chk("t4 ret in IDLE sig", 32'(bus.int_sig), 32'h0);

        // Reset during ACTIVE with pending source 3.
        pulse_irq(4'b0001);
        tick();
        do_ack();
        pulse_irq(4'b1000);
        bus.mask_we = 1'b1;
        bus.mask_wdata = 4'b0101;
        tick();
        bus.mask_we = 1'b0;
        chk("t5 pre pending", 32'(bus.pending), 32'h8);
        chk("t5 pre mask", 32'(bus.mask), 32'h5);
        chk("t5 pre in_service", 32'(bus.in_service), 32'h1);
        bus.irq_in = 4'b0010;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t5 rst");
`ifndef INTC_SYNC_EN
        repeat (3) tick();
        chk("t5 held line pending", 32'(bus.pending), 32'h0);
        chk("t5 held line sig", 32'(bus.int_sig), 32'h0);
`endif
        bus.irq_in = '0;
        repeat (LAT + 2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
